// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter with bounded burst lock in front of a single-port data memory.
// Optional grant statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
`ifdef DMEM_ARB_STATS_EN
  , parameter int STAT_W  = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wd0_i,
  input  logic [DATA_W-1:0] wd1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
`ifdef DMEM_ARB_STATS_EN
  output logic [STAT_W-1:0] grant_cnt0_o,
  output logic [STAT_W-1:0] grant_cnt1_o,
`endif
  input  logic [DATA_W-1:0] mem_rd_i
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  state_e state_q, state_d, other;
  logic [BW-1:0] burst_q, burst_d;
  logic last_q, last_d, own_req, oth_req;
  // State register: last starts at 1 so master 0 wins the first contended grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end
  // Next state: burst_cnt only advances under contention and forces handover at its limit
  always_comb begin
    own_req = state_q == OWN1 ? req1_i : req0_i;
    oth_req = state_q == OWN1 ? req0_i : req1_i;
    other   = state_q == OWN0 ? OWN1 : OWN0;
    state_d = state_q;
    burst_d = '0;
    if (state_q == IDLE)
      state_d = req0_i && (!req1_i || last_q) ? OWN0 : req1_i ? OWN1 : IDLE;
    else if (!own_req)
      state_d = oth_req ? other : IDLE;
    else if (oth_req && burst_q == BURST_LAST)
      state_d = other;
    else if (oth_req)
      burst_d = burst_q + 1'b1;
    last_d = state_d == OWN0 ? 1'b0 : state_d == OWN1 ? 1'b1 : last_q;
  end
  // Outputs: grant and memory mux are combinational from state, so reset clears them at once
  always_comb begin
    gnt0_o     = state_q == OWN0 && req0_i;
    gnt1_o     = state_q == OWN1 && req1_i;
    mem_we_o   = (gnt0_o && we0_i) || (gnt1_o && we1_i);
    mem_addr_o = gnt0_o ? addr0_i : gnt1_o ? addr1_i : '0;
    mem_wd_o   = gnt0_o ? wd0_i : gnt1_o ? wd1_i : '0;
    rdata_o    = mem_rd_i;
  end
`ifdef DMEM_ARB_STATS_EN
  // Saturating per-master granted-cycle counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt0_o <= '0;
      grant_cnt1_o <= '0;
    end else begin
      if (gnt0_o && !(&grant_cnt0_o)) grant_cnt0_o <= grant_cnt0_o + 1'b1;
      if (gnt1_o && !(&grant_cnt1_o)) grant_cnt1_o <= grant_cnt1_o + 1'b1;
    end
  end
`else
  // Statistics disabled: no counter state is built and arbitration is unchanged.
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;
  localparam int MB = 4;
  localparam int STAT_W = 16;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wd0 = 0, wd1 = 0;
  logic gnt0, gnt1, mem_we;
  logic [31:0] rdata, mem_addr, mem_wd, mem_rd;
  logic [31:0] mem [16] = '{default: 32'h0};
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  int own = -1, held = 0, tests = 0, fails = 0, e_cnt0 = 0, e_cnt1 = 0;
  bit last = 1'b1;
  logic o_g0, o_g1, o_we;
  logic [31:0] o_rd;
`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] cnt0, cnt1;
  logic [1:0] s_cnt0, s_cnt1;
  logic s_g0, s_g1, s_we;
  logic [31:0] s_rd, s_addr, s_wd;
`endif

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)
`ifdef DMEM_ARB_STATS_EN
    , .STAT_W(STAT_W)
`endif
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wd0_i(wd0), .wd1_i(wd1), .gnt0_o(gnt0), .gnt1_o(gnt1),
    .rdata_o(rdata), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
`ifdef DMEM_ARB_STATS_EN
    .grant_cnt0_o(cnt0), .grant_cnt1_o(cnt1),
`endif
    .mem_rd_i(mem_rd));

`ifdef DMEM_ARB_STATS_EN
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB), .STAT_W(2)) u_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .req0_i(1'b1), .req1_i(1'b0), .we0_i(1'b0), .we1_i(1'b0),
    .addr0_i(32'h0), .addr1_i(32'h0), .wd0_i(32'h0), .wd1_i(32'h0), .gnt0_o(s_g0), .gnt1_o(s_g1),
    .rdata_o(s_rd), .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_wd_o(s_wd),
    .grant_cnt0_o(s_cnt0), .grant_cnt1_o(s_cnt1), .mem_rd_i(32'h0));
`endif

  assign mem_rd = mem[mem_addr[5:2]];
  always @(posedge clk_i) if (mem_we) mem[mem_addr[5:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance the model at posedge.
  task automatic cyc(input logic r0, r1, w0, w1, input logic [31:0] a0, a1, d0, d1);
    logic eg0, eg1, ewe, mine, theirs;
    logic [31:0] ea, ed;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1; addr0 = a0; addr1 = a1; wd0 = d0; wd1 = d1;
    #1;
    eg0 = own == 0 && r0;
    eg1 = own == 1 && r1;
    ewe = (eg0 && w0) || (eg1 && w1);
    ea = eg0 ? a0 : eg1 ? a1 : 32'h0;
    ed = eg0 ? d0 : eg1 ? d1 : 32'h0;
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wd", mem_wd, ed);
    chk("rdata", rdata, ref_mem[ea[5:2]]);
    o_g0 = gnt0; o_g1 = gnt1; o_we = mem_we; o_rd = rdata;
    @(posedge clk_i);
    if (ewe) ref_mem[ea[5:2]] = ed;
    if (eg0 && e_cnt0 < (1 << STAT_W) - 1) e_cnt0++;
    if (eg1 && e_cnt1 < (1 << STAT_W) - 1) e_cnt1++;
    if (own < 0) begin
      if (r0 && r1) own = last ? 0 : 1;
      else if (r0) own = 0;
      else if (r1) own = 1;
      held = 0;
    end else begin
      mine = own == 0 ? r0 : r1;
      theirs = own == 0 ? r1 : r0;
      if (!mine) begin
        own = theirs ? 1 - own : -1;
        held = 0;
      end else if (!theirs) held = 0;
      else begin
        held++;
        if (held == MB) begin
          own = 1 - own;
          held = 0;
        end
      end
    end
    if (own >= 0) last = (own == 1);
    @(negedge clk_i);
`ifdef DMEM_ARB_STATS_EN
    chk("grant_cnt0", 32'(cnt0), e_cnt0);
    chk("grant_cnt1", 32'(cnt1), e_cnt1);
`endif
  endtask

  // Asynchronous reset asserted mid-cycle with whatever inputs are currently driven.
  task automatic do_reset();
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wd", mem_wd, 0);
    own = -1; held = 0; last = 1'b1; e_cnt0 = 0; e_cnt1 = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #1;
    chk("por_gnt0", gnt0, 0);
    chk("por_gnt1", gnt1, 0);
    chk("por_mem_we", mem_we, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(1, 0, 1, 0, 32'h20, 0, 32'h11111111, 0);
    cyc(1, 0, 1, 0, 32'h20, 0, 32'h11111111, 0);
    chk("s1_pre_gnt0", o_g0, 1);
    do_reset();
    cyc(1, 0, 1, 0, 32'h24, 0, 32'h22222222, 0);
    chk("s1_idle_after_rst", o_g0, 0);
    cyc(1, 0, 1, 0, 32'h10, 0, 32'hDEADBEEF, 0);
    chk("s1_regrant", o_g0, 1);
    chk("s2_we", o_we, 1);
    cyc(1, 0, 0, 0, 32'h10, 0, 32'h0, 0);
    chk("s2_readback", o_rd, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(1, 1, 0, 0, 32'h4, 32'h8, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0, 0, 32'h4, 32'h8, 0, 0);
      chk("s3_gnt0", o_g0, ((i / 4) % 2) == 0);
      chk("s3_gnt1", o_g1, ((i / 4) % 2) == 1);
      chk("s3_no_bubble", o_g0 | o_g1, 1);
    end
`ifdef DMEM_ARB_STATS_EN
    chk("s6_cnt0", 32'(cnt0), 8);
    chk("s6_cnt1", 32'(cnt1), 8);
`endif
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      cyc(0, 1, 0, 1, 0, 32'h30, 0, 32'(i));
      if (i > 0) chk("s4_hold", o_g1, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s4_release", o_g1, 0);
    cyc(0, 1, 0, 0, 0, 32'h30, 0, 0);
    chk("s4_idle_latency", o_g1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 32'h34, 0, 32'hA5A5A5A5, 0);
    cyc(1, 0, 1, 0, 32'h34, 0, 32'hA5A5A5A5, 0);
    cyc(0, 1, 1, 0, 32'h38, 32'h3C, 32'h5A5A5A5A, 0);
    chk("s5_drop_gnt0", o_g0, 0);
    chk("s5_drop_we", o_we, 0);
    cyc(0, 1, 1, 0, 32'h38, 32'h3C, 32'h5A5A5A5A, 0);
    chk("s5_handover", o_g1, 1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, {26'd0, 4'($urandom_range(0, 15)), 2'b00},
          {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, $urandom);
`ifdef DMEM_ARB_STATS_EN
    chk("s6_saturate", 32'(s_cnt0), 3);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
